// File: rtl/gf_mult_pkg.sv
// Shared definitions for the GF(2^M) digit-serial multiplier.
//   DEFAULT_M / DEFAULT_D : default field degree and digit width
//   state_t               : controller states (IDLE, CAL)
//   cnt_width()           : width of the digit counter for K = M/D digits
package gf_mult_pkg;

    localparam int DEFAULT_M = 8;
    localparam int DEFAULT_D = 2;

    typedef enum logic {
        IDLE = 1'b0,
        CAL  = 1'b1
    } state_t;

    // The counter has to be able to hold the values 0..K.
    function automatic int cnt_width(input int k);
        return $clog2(k + 1);
    endfunction

endpackage

// File: rtl/gf2m_digit_serial_mult_if.sv
// Request/response bundle for gf2m_digit_serial_mult.
//   start  : request a product; the multiplier takes it only while not busy
//   a, b   : operands (polynomial basis, bit i = coefficient of x^i)
//   g      : low M coefficients of the field polynomial (x^M implicit)
//   busy   : a product is in progress; start is ignored while high
//   result : last completed product, held until the next completion
//   done   : one-cycle pulse when result has just been updated
//
// Handshake: start acts as valid and (!busy) as ready. A request is taken on
// a rising edge where start=1 and the multiplier is idle; a, b and g are
// captured on that same edge and may change freely afterwards. There is no
// back-pressure on the response: done is a single-cycle pulse and result
// stays stable until the next pulse.
interface gf2m_digit_serial_mult_if
    import gf_mult_pkg::*;
#(
    parameter int M = DEFAULT_M
);
    logic         start;
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic [M-1:0] g;
    logic         busy;
    logic [M-1:0] result;
    logic         done;

    modport master (
        output start, a, b, g,
        input  busy, result, done
    );

    modport slave (
        input  start, a, b, g,
        output busy, result, done
    );
endinterface

// File: rtl/gf_digit_cell.sv
// One digit step of the MSB-digit-first multiplier, purely combinational:
//   t_next = (t * x^D mod p) xor (a * digit mod p),  p = x^M + g
// Evaluated Horner style: D single-bit steps, each a multiply-by-x with
// reduction (shift left, xor g when the shifted-out bit is 1) followed by
// a conditional add of a for the matching digit bit.
//   t     : current accumulator
//   a     : multiplicand
//   g     : field polynomial low coefficients
//   digit : D-bit slice of the multiplier, MSB is the highest power
//   t_next: next accumulator
module gf_digit_cell
    import gf_mult_pkg::*;
#(
    parameter int M = DEFAULT_M,
    parameter int D = DEFAULT_D
) (
    input  logic [M-1:0] t,
    input  logic [M-1:0] a,
    input  logic [M-1:0] g,
    input  logic [D-1:0] digit,
    output logic [M-1:0] t_next
);

    logic [M-1:0] acc;

    always_comb begin
        acc = t;
        for (int i = D - 1; i >= 0; i--) begin
            acc = (acc << 1) ^ ({M{acc[M-1]}} & g);
            if (digit[i]) begin
                acc = acc ^ a;
            end
        end
        t_next = acc;
    end

endmodule

// File: rtl/gf2m_digit_serial_mult.sv
// Digit-serial GF(2^M) multiplier, result = a*b mod (x^M + g).
// Consumes D bits of b per cycle, most significant digit first, so a product
// takes K = M/D cycles in CAL plus one IDLE cycle to accept the next request.
// M must be a multiple of D.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : request/response bundle (slave side)
//   fsm_state : controller state, for observation
module gf2m_digit_serial_mult
    import gf_mult_pkg::*;
#(
    parameter int M = DEFAULT_M,
    parameter int D = DEFAULT_D
) (
    input  logic                        clk,
    input  logic                        rst_n,
    gf2m_digit_serial_mult_if.slave     bus,
    output state_t                      fsm_state
);

    localparam int K     = M / D;
    localparam int CNT_W = cnt_width(K);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [M-1:0]     a_q;
    logic [M-1:0]     b_q;
    logic [M-1:0]     g_q;
    logic [M-1:0]     t_q;
    logic [M-1:0]     t_next;
    logic [M-1:0]     result_q;
    logic             busy_q;
    logic             done_q;
    logic [D-1:0]     digit;

    // Digit select as a constant-index mux: only counter values 0..K-1 pick
    // a slice, so b is never indexed out of range even if cnt were corrupt.
    always_comb begin
        digit = '0;
        for (int k = 0; k < K; k++) begin
            if (cnt == CNT_W'(k)) begin
                digit = b_q[(K - k) * D - 1 -: D];
            end
        end
    end

    gf_digit_cell #(
        .M (M),
        .D (D)
    ) u_cell (
        .t      (t_q),
        .a      (a_q),
        .g      (g_q),
        .digit  (digit),
        .t_next (t_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            g_q      <= '0;
            t_q      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q    <= bus.a;
                        b_q    <= bus.b;
                        g_q    <= bus.g;
                        t_q    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= CAL;
                    end
                end
                CAL: begin
                    t_q <= t_next;
                    cnt <= cnt + 1'b1;
                    // Last digit: publish the product straight from the cell
                    // so done lines up with the K-th CAL edge.
                    if (cnt == CNT_W'(K - 1)) begin
                        result_q <= t_next;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.result = result_q;
    assign bus.done   = done_q;
    assign fsm_state  = state;

endmodule

// File: tb/tb_gf2m_digit_serial_mult.sv
// Directed bench for gf2m_digit_serial_mult: three instances (D=2, D=1, D=8)
// sharing one clock and reset, checked against hand-computed AES-field
// products and an LSB-first shift-and-add reference model.
module tb_gf2m_digit_serial_mult;
    import gf_mult_pkg::*;

    logic   clk;
    logic   rst_n;
    state_t st2, st1, st8;
    int     total = 0;
    int     bad   = 0;

    gf2m_digit_serial_mult_if #(.M(8)) bus2 ();
    gf2m_digit_serial_mult_if #(.M(8)) bus1 ();
    gf2m_digit_serial_mult_if #(.M(8)) bus8 ();

    gf2m_digit_serial_mult #(.M(8), .D(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2), .fsm_state(st2));
    gf2m_digit_serial_mult #(.M(8), .D(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1), .fsm_state(st1));
    gf2m_digit_serial_mult #(.M(8), .D(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8), .fsm_state(st8));

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] xtime(input logic [7:0] v, input logic [7:0] gp);
        return {v[6:0], 1'b0} ^ (v[7] ? gp : 8'h00);
    endfunction

    // LSB-first shift-and-add: r = sum b_i * (a * x^i mod p)
    function automatic logic [7:0] gf_ref(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] gp);
        logic [7:0] r;
        logic [7:0] sh;
        r  = 8'h00;
        sh = av;
        for (int i = 0; i < 8; i++) begin
            if (bv[i]) r = r ^ sh;
            sh = xtime(sh, gp);
        end
        return r;
    endfunction

    // ---------------- scoreboard check ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver helpers ----------------
    function automatic logic get_done(input int w);
        case (w)
            1:       return bus1.done;
            8:       return bus8.done;
            default: return bus2.done;
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            1:       return bus1.busy;
            8:       return bus8.busy;
            default: return bus2.busy;
        endcase
    endfunction

    function automatic logic [7:0] get_result(input int w);
        case (w)
            1:       return bus1.result;
            8:       return bus8.result;
            default: return bus2.result;
        endcase
    endfunction

    task automatic set_req(input int w, input logic s, input logic [7:0] av, input logic [7:0] bv, input logic [7:0] gv);
        case (w)
            1: begin bus1.start = s; bus1.a = av; bus1.b = bv; bus1.g = gv; end
            8: begin bus8.start = s; bus8.a = av; bus8.b = bv; bus8.g = gv; end
            default: begin bus2.start = s; bus2.a = av; bus2.b = bv; bus2.g = gv; end
        endcase
    endtask

    task automatic set_start(input int w, input logic s);
        case (w)
            1:       bus1.start = s;
            8:       bus8.start = s;
            default: bus2.start = s;
        endcase
    endtask

    // Called 1 time unit after a rising edge; returns just after the edge
    // that sampled the request.
    task automatic issue(input int w, input logic [7:0] av, input logic [7:0] bv, input logic [7:0] gv);
        set_req(w, 1'b1, av, bv, gv);
        @(posedge clk); #1;
        set_start(w, 1'b0);
    endtask

    // Counts edges after the sampling edge until done; bounded.
    task automatic wait_done(input int w, input string tag, output int lat, output int bcnt, output logic [7:0] res);
        logic found;
        found = 1'b0;
        lat   = 0;
        bcnt  = int'(get_busy(w));
        while (!found && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (get_done(w)) found = 1'b1;
            else bcnt += int'(get_busy(w));
        end
        check({tag, "_done_seen"}, 32'(found), 32'd1);
        res = get_result(w);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int         lat;
        int         bcnt;
        int         ndone;
        logic [7:0] res;
        logic [7:0] av, bv, gv;

        rst_n = 1'b0;
        set_req(2, 1'b0, 8'h00, 8'h00, 8'h00);
        set_req(1, 1'b0, 8'h00, 8'h00, 8'h00);
        set_req(8, 1'b0, 8'h00, 8'h00, 8'h00);
        @(posedge clk); @(posedge clk); #1;

        // Reset state
        check("rst_result", 32'(bus2.result), 32'h00);
        check("rst_busy",   32'(bus2.busy),   32'h0);
        check("rst_done",   32'(bus2.done),   32'h0);
        check("rst_state",  32'(st2),         32'(IDLE));

        // First start on the first edge with rst_n high
        rst_n = 1'b1;
        issue(2, 8'h57, 8'h83, 8'h1B);
        check("basic_busy_state", 32'(st2), 32'(CAL));
        wait_done(2, "basic", lat, bcnt, res);
        check("basic_result",  32'(res),  32'hC1);
        check("basic_latency", 32'(lat),  32'd4);
        check("basic_busy_cycles", 32'(bcnt), 32'd4);
        check("basic_busy_low_at_done", 32'(bus2.busy), 32'd0);

        // Back-to-back: new request in the cycle done is high
        issue(2, 8'h57, 8'h13, 8'h1B);
        check("b2b_done_one_cycle", 32'(bus2.done), 32'd0);
        check("b2b_result_held", 32'(bus2.result), 32'hC1);
        wait_done(2, "b2b", lat, bcnt, res);
        check("b2b_result", 32'(res), 32'hFE);
        check("b2b_gap", 32'(lat + 1), 32'd5);

        // start held through CAL with changing operands
        set_req(2, 1'b1, 8'h57, 8'h83, 8'h1B);
        @(posedge clk); #1;
        lat   = 0;
        ndone = 0;
        while (ndone == 0 && lat < 20) begin
            bus2.a = 8'($urandom_range(0, 255));
            bus2.b = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
            lat++;
            if (bus2.done) ndone++;
        end
        set_start(2, 1'b0);
        check("hold_result",  32'(bus2.result), 32'hC1);
        check("hold_latency", 32'(lat), 32'd4);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus2.done) ndone++;
        end
        check("hold_no_extra_done", 32'(ndone), 32'd0);
        check("hold_idle_after", 32'(bus2.busy), 32'd0);

        // Reset in the second CAL cycle
        issue(2, 8'h57, 8'h83, 8'h1B);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy",   32'(bus2.busy),   32'd0);
        check("midrst_done",   32'(bus2.done),   32'd0);
        check("midrst_result", 32'(bus2.result), 32'h00);
        check("midrst_state",  32'(st2),         32'(IDLE));
        @(posedge clk); #1;
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus2.done) ndone++;
        end
        check("midrst_no_done", 32'(ndone), 32'd0);
        issue(2, 8'h57, 8'h13, 8'h1B);
        wait_done(2, "postrst", lat, bcnt, res);
        check("postrst_result", 32'(res), 32'hFE);

        // Digit-width sweep
        issue(1, 8'h57, 8'h83, 8'h1B);
        wait_done(1, "d1", lat, bcnt, res);
        check("d1_result",  32'(res), 32'hC1);
        check("d1_latency", 32'(lat), 32'd8);
        issue(8, 8'h57, 8'h83, 8'h1B);
        wait_done(8, "d8", lat, bcnt, res);
        check("d8_result",  32'(res),  32'hC1);
        check("d8_latency", 32'(lat),  32'd1);
        check("d8_busy_cycles", 32'(bcnt), 32'd1);

        // Identity and zero operands
        issue(2, 8'h00, 8'h83, 8'h1B);
        wait_done(2, "a_zero", lat, bcnt, res);
        check("a_zero_result", 32'(res), 32'h00);
        issue(2, 8'hA5, 8'h00, 8'h1B);
        wait_done(2, "b_zero", lat, bcnt, res);
        check("b_zero_result", 32'(res), 32'h00);
        issue(2, 8'hA5, 8'h01, 8'h1B);
        wait_done(2, "b_one", lat, bcnt, res);
        check("b_one_result", 32'(res), 32'hA5);
        issue(8, 8'hFF, 8'h01, 8'h1B);
        wait_done(8, "d8_b_one", lat, bcnt, res);
        check("d8_b_one_result", 32'(res), 32'hFF);

        // Randomised products, arbitrary g
        for (int i = 0; i < 1000; i++) begin
            av = 8'($urandom_range(0, 255));
            bv = 8'($urandom_range(0, 255));
            gv = 8'($urandom_range(0, 255));
            issue(2, av, bv, gv);
            wait_done(2, "rnd2", lat, bcnt, res);
            check("rnd2_result", 32'(res), 32'(gf_ref(av, bv, gv)));
        end
        for (int i = 0; i < 100; i++) begin
            av = 8'($urandom_range(0, 255));
            bv = 8'($urandom_range(0, 255));
            gv = 8'($urandom_range(0, 255));
            issue(1, av, bv, gv);
            wait_done(1, "rnd1", lat, bcnt, res);
            check("rnd1_result", 32'(res), 32'(gf_ref(av, bv, gv)));
            issue(8, av, bv, gv);
            wait_done(8, "rnd8", lat, bcnt, res);
            check("rnd8_result", 32'(res), 32'(gf_ref(av, bv, gv)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gf2m_digit_serial_mult.md
GF2M_DIGIT_SERIAL_MULT -- requirements
Module: gf2m_digit_serial_mult

Interface
REQ-001 Parameter M, default 8: field degree; operand and result width.
REQ-002 Parameter D, default 2: digit width; M SHALL be a multiple of D; K = M/D digit cycles per product.
REQ-003 clk  input  1: sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1: reset; asynchronous, active-low.
REQ-005 start  input  1: request a product; sampled only in IDLE.
REQ-006 a  input  M: multiplicand, polynomial basis, bit i = coefficient of x^i.
REQ-007 b  input  M: multiplier; digits consumed MSB-digit first.
REQ-008 g  input  M: field polynomial low M coefficients; x^M term implicit.
REQ-009 busy  output  1: high while a product is in progress.
REQ-010 result  output  M: last completed product a*b mod (x^M+g); held until the next completion.
REQ-011 done  output  1: one-cycle pulse marking a new result.

Function
REQ-012 FSM states: IDLE, CAL; no terminal state; the block always returns to IDLE.
REQ-013 IDLE with start=1 at edge n: latch a, b, g; clear accumulator T; digit counter := 0; go to CAL.
REQ-014 CAL, edges n+1..n+K: T := (T*x^D mod p) xor (a*b_digit mod p), where p = x^M+g and b_digit = b[(K-c)*D-1 -: D] for counter c.
REQ-015 Reduction: D sequential single-bit steps per cycle, combinational; shift left 1, xor g if the shifted-out bit = 1.
REQ-016 Counter: increments each CAL cycle; width clog2(K+1); it SHALL never index outside b.
REQ-017 At edge n+K: result := final T; done := 1 for exactly one cycle; state := IDLE.
REQ-018 Latency: done visible K cycles after the start-sampling edge; throughput one product per K+1 cycles.
REQ-019 busy = (state == CAL), registered.
REQ-020 start while busy: ignored; latched operands are unchanged.
REQ-021 start in the cycle done is high: state is IDLE, so the request is accepted; back-to-back operation is legal.
REQ-022 Operands a and b SHALL be of degree < M; g is not checked, and results follow the arithmetic for any g.
REQ-023 K=1 (D=M): single-cycle CAL; K=M (D=1): bit-serial; both SHALL be functional.
REQ-024 a=0 or b=0 -> result 0; b=1 -> result a.

Reset
REQ-025 rst_n low, at any time including mid-CAL: state IDLE, busy 0, done 0, result 0, counter 0, operand registers 0, T 0.
REQ-026 A product interrupted by reset SHALL NOT produce done after rst_n is released.
REQ-027 The first start is accepted on the first rising edge with rst_n high.

Structure
REQ-028 Shared package gf_mult_pkg: default M and D, the state enum typedef {IDLE, CAL}, and the counter-width function.
REQ-029 One sub-module gf_digit_cell: combinational, one digit step (inputs T, a, g, digit; output next T), parametrised by M and D.
REQ-030 Top holds the FSM, counter, operand registers, and result/done registers only.

Verification
REQ-031 M=8, D=2, g=0x1B, a=0x57, b=0x83, start one cycle -> done pulse after 4 cycles, result=0xC1, busy high exactly 4 cycles.
REQ-032 Same setup, a=0x57, b=0x13 issued in the cycle done is high -> second done 5 cycles after the first, result=0xFE.
REQ-033 start held high continuously during CAL with changing a/b -> first result 0xC1 unaffected; no extra done.
REQ-034 rst_n low at CAL cycle 2 -> all outputs 0 immediately; no done afterwards; a new start then yields a correct product.
REQ-035 Parameter sweep D=1 (K=8) and D=8 (K=1), g=0x1B, 0x57*0x83 -> 0xC1 with latency 8 and 1 respectively.
REQ-036 a=0x00 or b=0x00 -> 0x00; b=0x01 -> a; randomised 1000 products checked against a bit-serial reference model.
